// File: rtl/disp_data_hold_pkg.sv
// Shared constants and helpers for the display data holder.
// Covers the field width, the 4-digit display limit, refresh period arithmetic and the field clamp.
package disp_pkg;

  localparam int DISP_W = 16;
  localparam logic [DISP_W-1:0] DISP_MAX = 16'd9999;

  function automatic int ref_cycles(input int clk_freq, input int ms);
    return (clk_freq / 1000) * ms;
  endfunction

  function automatic logic [DISP_W-1:0] disp_clamp(input logic [DISP_W-1:0] v);
    if (v > DISP_MAX) begin
      return DISP_MAX;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/disp_data_hold_if.sv
// Measurement strobe / display word bundle between the feeder logic and disp_data_hold.
// The master drives samples and freeze; the slave (disp_data_hold) drives data and data_upd.
interface disp_data_hold_if;
  import disp_pkg::*;

  logic              x_valid;
  logic [DISP_W-1:0] x_data;
  logic              y_valid;
  logic [DISP_W-1:0] y_data;
  logic              freeze;
  logic [2*DISP_W-1:0] data;
  logic              data_upd;

  modport master (
    output x_valid, x_data, y_valid, y_data, freeze,
    input  data, data_upd
  );

  modport slave (
    input  x_valid, x_data, y_valid, y_data, freeze,
    output data, data_upd
  );

endinterface

// File: rtl/disp_data_hold_chan_avg.sv
// One measurement channel: box-car average over 2^AVG_LOG2 samples, fresh/stale tracking on
// refresh ticks, and the displayed value. Optional 9999 clamp under DISP_CLAMP_EN.
module disp_chan_avg
  import disp_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int STALE_N  = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              valid,
  input  logic [DISP_W-1:0] sample,
  input  logic              tick,
  // Value the channel displays after this cycle; the top registers it on a publish.
  output logic [DISP_W-1:0] disp
);

  localparam int ACC_W = DISP_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DISP_W-1:0] avg_q, avg_d;
  logic              fresh_q, fresh_d;
  logic [3:0]        stale_q, stale_d;
  logic [DISP_W-1:0] disp_q, disp_d;

  logic [ACC_W-1:0]  sum_s;
  logic [DISP_W-1:0] avg_new_s;
  logic [DISP_W-1:0] pub_s;
  logic              done_s;

  assign sum_s     = acc_q + ACC_W'(sample);
  assign avg_new_s = sum_s[AVG_LOG2 +: DISP_W];
  assign done_s    = valid && (cnt_q == CNT_LAST);

`ifdef DISP_CLAMP_EN
  assign pub_s = disp_clamp(avg_d);
`else
  assign pub_s = avg_d;
`endif

  // Accumulate samples, then apply tick bookkeeping to the post-strobe average/fresh state
  // so that an average completing on the tick cycle is published on that same tick.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    fresh_d = fresh_q;
    stale_d = stale_q;
    disp_d  = disp_q;

    if (valid) begin
      if (done_s) begin
        acc_d   = '0;
        cnt_d   = '0;
        avg_d   = avg_new_s;
        fresh_d = 1'b1;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      acc_d = acc_q;
    end

    if (tick) begin
      if (fresh_d) begin
        disp_d  = pub_s;
        stale_d = 4'd0;
        fresh_d = 1'b0;
      end else begin
        if (stale_q < 4'(STALE_N)) begin
          stale_d = stale_q + 4'd1;
        end else begin
          stale_d = stale_q;
        end
        if (stale_d >= 4'(STALE_N)) begin
          disp_d = '0;
        end else begin
          disp_d = disp_q;
        end
      end
    end else begin
      stale_d = stale_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      fresh_q <= 1'b0;
      stale_q <= 4'd0;
      disp_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      fresh_q <= fresh_d;
      stale_q <= stale_d;
      disp_q  <= disp_d;
    end
  end

  assign disp = disp_d;

endmodule

// File: rtl/disp_data_hold.sv
// Averages X/Y measurement strobes and publishes {X, Y} once per refresh period, holding it in between.
// Build option DISP_CLAMP_EN clamps each published field to 9999.
module disp_data_hold
  import disp_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int REFRESH_MS = 200,
  parameter int AVG_LOG2   = 3,
  parameter int STALE_N    = 3
) (
  input logic            sys_clk,
  input logic            sys_rst,
  disp_data_hold_if.slave bus
);

  localparam int REF_CYC = ref_cycles(CLK_FREQ, REFRESH_MS);
  localparam int TMR_W   = (REF_CYC > 1) ? $clog2(REF_CYC) : 1;

  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [2*DISP_W-1:0] data_q, data_d;
  logic                upd_q, upd_d;

  logic                tick_s;
  logic [DISP_W-1:0]   x_disp_s, y_disp_s;

  assign tick_s = (tmr_q == TMR_W'(REF_CYC - 1));

  disp_chan_avg #(.AVG_LOG2(AVG_LOG2), .STALE_N(STALE_N)) u_x (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .valid   (bus.x_valid),
    .sample  (bus.x_data),
    .tick    (tick_s),
    .disp    (x_disp_s)
  );

  disp_chan_avg #(.AVG_LOG2(AVG_LOG2), .STALE_N(STALE_N)) u_y (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .valid   (bus.y_valid),
    .sample  (bus.y_data),
    .tick    (tick_s),
    .disp    (y_disp_s)
  );

  // Free-running refresh timer; freeze only gates the publish, never the timer.
  always_comb begin
    if (tick_s) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    if (tick_s && !bus.freeze) begin
      data_d = {x_disp_s, y_disp_s};
      upd_d  = 1'b1;
    end else begin
      data_d = data_q;
      upd_d  = 1'b0;
    end
  end

  // Timer and published word registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tmr_q  <= '0;
      data_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      data_q <= data_d;
      upd_q  <= upd_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.data_upd = upd_q;

endmodule

// File: doc/disp_data_hold.md
Name: disp_data_hold

Overview:
- Upstream feeder of the LCD character display top; produces its 32-bit `data` word, X in [31:16] and Y in [15:0].
- Takes raw 16-bit X and Y measurement strobes from the measurement logic and box-car averages each channel over 2^AVG_LOG2 samples.
- Publishes both averages together at a fixed, readable refresh rate, holding the word stable in between.
- Blanks a channel to 0 when its source goes stale.

Parameters:
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- REFRESH_MS, 200: display update period in ms. Refresh period REF_CYC = (CLK_FREQ/1000)*REFRESH_MS cycles.
- AVG_LOG2, 3: log2 of the samples averaged per channel. Range 0..6; 0 means pass-through of the last sample.
- STALE_N, 3: consecutive refreshes without a new average before a channel is forced to 0. Range 1..15.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst, in, 1: asynchronous active-high reset.
- x_valid, in, 1: single-cycle strobe; x_data is valid.
- x_data, in, 16: unsigned X sample.
- y_valid, in, 1: single-cycle strobe; y_data is valid.
- y_data, in, 16: unsigned Y sample.
- freeze, in, 1: level; when high, published output does not change.
- data, out, 32: {x_disp, y_disp}, to the LCD character top.
- data_upd, out, 1: one-cycle pulse when data is re-registered.

Behaviour:
- Reset (async assert; release is sampled on a sys_clk edge):
  - data=0, data_upd=0.
  - All accumulators, sample counters, refresh timer, stale counters and fresh flags = 0.
- Per channel (X and Y are identical and independent):
  - acc is 16+AVG_LOG2 bits. cnt is AVG_LOG2 bits.
  - On a valid strobe: acc += sample and cnt += 1.
  - On the strobe where cnt == 2^AVG_LOG2-1:
    - avg <= (acc + sample) >> AVG_LOG2 (floor, includes the current sample).
    - acc <= 0, cnt <= 0, fresh <= 1.
  - No overflow is possible by width; no saturation logic.
  - A valid strobe may arrive on consecutive cycles. Each one is accepted; there is no back-pressure.
- Refresh timer:
  - tmr counts 0..REF_CYC-1 and wraps.
  - The terminal cycle (tmr == REF_CYC-1) is a "tick".
  - It runs free, including while freeze=1.
- On a tick, per channel:
  - If fresh=1: disp <= avg, stale_cnt <= 0, fresh <= 0.
  - Otherwise, stale_cnt saturates upward. When it reaches STALE_N, disp <= 0.
- Same cycle as a tick, if freeze=0: data <= {x_disp_next, y_disp_next} and data_upd=1 on the following cycle edge.
  - Latency: tick cycle +1 clock to visible data and data_upd.
- If freeze=1 on a tick:
  - data and data_upd do not change.
  - fresh/stale bookkeeping still updates.
  - The first tick after freeze falls publishes current values.
- Simultaneous average-completion and tick on the same cycle:
  - The new average is published on that tick.
  - fresh ends 0.
- data_upd pulses every unfrozen tick, even if the values are unchanged.
- Reset mid-accumulation discards partial sums; the first publish after reset is at tick REF_CYC-1.

Optional Feature:
- Macro DISP_CLAMP_EN.
- Defined:
  - Each 16-bit field of data is clamped to 9999 (0x270F) before registering, matching the 4-digit BCD display.
  - Values >= 10000 show 9999.
- Not defined:
  - Raw 16-bit averages are passed unmodified.
  - Values >= 10000 are left to the display path.

Decomposition:
- Package disp_pkg:
  - DISP_MAX = 16'd9999.
  - Field width constant DISP_W = 16.
  - Function ref_cycles(clk_freq, ms) returning REF_CYC.
- One natural sub-module, disp_chan_avg, instantiated twice (X, Y).
  - Contains the accumulator, sample counter, avg/fresh, stale counter, disp, and the optional clamp.
  - Ports: sys_clk, sys_rst, valid, sample, tick, disp.
- The top holds the refresh timer, freeze gating, data and data_upd registers.

Test Plan:
All scenarios use CLK_FREQ=1000, REFRESH_MS=20 (REF_CYC=20), AVG_LOG2=2, STALE_N=3.
1. Averaging: X samples 10,11,12,13 within one period; Y samples 4×100 → after the tick, data=0x000B_0064 (floor 46/4=11) with one data_upd pulse.
2. Hold and stale: no strobes after scenario 1 → data stays 0x000B_0064 for 2 ticks; on the 3rd tick it becomes 0x0000_0000. data_upd pulses on every tick.
3. Freeze: freeze=1, X average 500 completes → data unchanged and no data_upd across 2 ticks; freeze=0 → next tick publishes X=500 (0x01F4).
4. Coincidence: the 4th X strobe lands exactly on the tick cycle → that average is published on that tick, one cycle later.
5. Clamp: X samples 4×60000 → data[31:16]=0x270F with DISP_CLAMP_EN defined, 0xEA60 without.
6. Reset: assert sys_rst after 2 of 4 X samples → data=0 and data_upd=0 immediately; after release, the next 4 samples of 8 → X=8 on the first tick.
